// File: rtl/cpu_pkg.sv
// Shared opcode, step and control-word definitions for the CPU control unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } tstate_e;

  localparam tstate_e T_MAX = T5;

  typedef struct packed {
    logic pc_en;
    logic pc_out;
    logic pc_in;
    logic mar_in;
    logic ram_out;
    logic ram_in;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic alu_sub;
    logic flags_in;
    logic out_in;
  } ctrl_t;

  // Undefined opcodes (0x9..0xD) fold onto NOP or HLT so the decoder only sees defined ones.
  function automatic opcode_e decode_opcode(input logic [3:0] raw, input bit illegal_halt);
    if (raw inside {[4'h9:4'hD]}) begin
      return illegal_halt ? OP_HLT : OP_NOP;
    end
    return opcode_e'(raw);
  endfunction

endpackage

// File: rtl/cpu_tstate.sv
// Instruction step counter: T0..T5, with hold and early return to T0.
module cpu_tstate
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    hold,
  input  logic    last,
  output tstate_e t_state
);

  tstate_e t_q;
  tstate_e t_d;

  always_comb begin
    t_d = t_q;
    if (!hold) begin
      if (last || t_q == T_MAX) begin
        t_d = T0;
      end else begin
        t_d = tstate_e'(t_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= T0;
    end else begin
      t_q <= t_d;
    end
  end

  assign t_state = t_q;

endmodule

// File: rtl/cpu_ctrl.sv
// Microcoded control unit for the 8-bit bus CPU: fetch/execute sequencing and
// combinational decode of the control word from step, opcode and flags.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_en,
  output logic       pc_out,
  output logic       pc_in,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       halt,
  output logic [2:0] t_state,
  output logic       instr_done
);

  tstate_e step;
  opcode_e op;
  ctrl_t   ctrl;
  logic    run;
  logic    halt_q;
  logic    active;
  logic    last_step;
  logic    halt_set;

  assign op     = decode_opcode(opcode, ILLEGAL_HALT);
  assign active = run && !halt_q;

  // run rises one edge after reset release, giving a single idle cycle before T0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (halt_set) begin
      halt_q <= 1'b1;
    end
  end

  cpu_tstate u_tstate (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (!active),
    .last    (last_step),
    .t_state (step)
  );

  // Everything is gated by active, so reset or halt silences the bus in the same cycle.
  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    halt_set  = 1'b0;
    if (active) begin
      case (step)
        T0: begin
          ctrl.pc_out = 1'b1;
          ctrl.mar_in = 1'b1;
        end
        T1: begin
          ctrl.ram_out = 1'b1;
          ctrl.ir_in   = 1'b1;
          ctrl.pc_en   = 1'b1;
        end
        default: begin
          case (op)
            OP_LDA: begin
              if (step == T2) begin
                ctrl.ir_out = 1'b1;
                ctrl.mar_in = 1'b1;
              end else begin
                ctrl.ram_out = 1'b1;
                ctrl.a_in    = 1'b1;
                last_step    = 1'b1;
              end
            end
            OP_ADD, OP_SUB: begin
              case (step)
                T2: begin
                  ctrl.ir_out = 1'b1;
                  ctrl.mar_in = 1'b1;
                end
                T3: begin
                  ctrl.ram_out = 1'b1;
                  ctrl.b_in    = 1'b1;
                end
                default: begin
                  ctrl.alu_out  = 1'b1;
                  ctrl.a_in     = 1'b1;
                  ctrl.flags_in = 1'b1;
                  ctrl.alu_sub  = (op == OP_SUB);
                  last_step     = 1'b1;
                end
              endcase
            end
            OP_STA: begin
              if (step == T2) begin
                ctrl.ir_out = 1'b1;
                ctrl.mar_in = 1'b1;
              end else begin
                ctrl.a_out  = 1'b1;
                ctrl.ram_in = 1'b1;
                last_step   = 1'b1;
              end
            end
            OP_LDI: begin
              ctrl.ir_out = 1'b1;
              ctrl.a_in   = 1'b1;
              last_step   = 1'b1;
            end
            OP_JMP: begin
              ctrl.ir_out = 1'b1;
              ctrl.pc_in  = 1'b1;
              last_step   = 1'b1;
            end
            OP_JC: begin
              ctrl.ir_out = 1'b1;
              ctrl.pc_in  = carry_flag;
              last_step   = 1'b1;
            end
            OP_JZ: begin
              ctrl.ir_out = 1'b1;
              ctrl.pc_in  = zero_flag;
              last_step   = 1'b1;
            end
            OP_OUT: begin
              ctrl.a_out  = 1'b1;
              ctrl.out_in = 1'b1;
              last_step   = 1'b1;
            end
            OP_HLT: begin
              halt_set  = 1'b1;
              last_step = 1'b1;
            end
            default: begin
              last_step = 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign pc_out     = ctrl.pc_out;
  assign pc_in      = ctrl.pc_in;
  assign mar_in     = ctrl.mar_in;
  assign ram_out    = ctrl.ram_out;
  assign ram_in     = ctrl.ram_in;
  assign ir_in      = ctrl.ir_in;
  assign ir_out     = ctrl.ir_out;
  assign a_in       = ctrl.a_in;
  assign a_out      = ctrl.a_out;
  assign b_in       = ctrl.b_in;
  assign alu_out    = ctrl.alu_out;
  assign alu_sub    = ctrl.alu_sub;
  assign flags_in   = ctrl.flags_in;
  assign out_in     = ctrl.out_in;
  assign halt       = halt_q;
  assign t_state    = step;
  assign instr_done = last_step;

  bus_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({ctrl.pc_out, ctrl.ram_out, ctrl.ir_out, ctrl.a_out, ctrl.alu_out}));

  halt_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    halt_q |-> (ctrl == '0 && !last_step));

  halt_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    halt_q |=> halt_q);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed instruction scenarios plus a random
// opcode stream compared against a table-driven step model.
module tb_cpu_ctrl;

  localparam logic [14:0] PC_EN    = 15'd1 << 0;
  localparam logic [14:0] PC_OUT   = 15'd1 << 1;
  localparam logic [14:0] PC_IN    = 15'd1 << 2;
  localparam logic [14:0] MAR_IN   = 15'd1 << 3;
  localparam logic [14:0] RAM_OUT  = 15'd1 << 4;
  localparam logic [14:0] RAM_IN   = 15'd1 << 5;
  localparam logic [14:0] IR_IN    = 15'd1 << 6;
  localparam logic [14:0] IR_OUT   = 15'd1 << 7;
  localparam logic [14:0] A_IN     = 15'd1 << 8;
  localparam logic [14:0] A_OUT    = 15'd1 << 9;
  localparam logic [14:0] B_IN     = 15'd1 << 10;
  localparam logic [14:0] ALU_OUT  = 15'd1 << 11;
  localparam logic [14:0] ALU_SUB  = 15'd1 << 12;
  localparam logic [14:0] FLAGS_IN = 15'd1 << 13;
  localparam logic [14:0] OUT_IN   = 15'd1 << 14;
  localparam logic [14:0] BUS      = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n[2];
  logic [3:0] opcode[2];
  logic       carry_flag[2], zero_flag[2];
  logic       pc_en[2], pc_out[2], pc_in[2], mar_in[2], ram_out[2], ram_in[2];
  logic       ir_in[2], ir_out[2], a_in[2], a_out[2], b_in[2];
  logic       alu_out[2], alu_sub[2], flags_in[2], out_in[2], halt[2], instr_done[2];
  logic [2:0] t_state[2];

  int pass_count;
  int check_count;

  cpu_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .opcode(opcode[0]),
    .carry_flag(carry_flag[0]), .zero_flag(zero_flag[0]),
    .pc_en(pc_en[0]), .pc_out(pc_out[0]), .pc_in(pc_in[0]),
    .mar_in(mar_in[0]), .ram_out(ram_out[0]), .ram_in(ram_in[0]),
    .ir_in(ir_in[0]), .ir_out(ir_out[0]), .a_in(a_in[0]), .a_out(a_out[0]),
    .b_in(b_in[0]), .alu_out(alu_out[0]), .alu_sub(alu_sub[0]),
    .flags_in(flags_in[0]), .out_in(out_in[0]), .halt(halt[0]),
    .t_state(t_state[0]), .instr_done(instr_done[0])
  );

  cpu_ctrl #(.ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .opcode(opcode[1]),
    .carry_flag(carry_flag[1]), .zero_flag(zero_flag[1]),
    .pc_en(pc_en[1]), .pc_out(pc_out[1]), .pc_in(pc_in[1]),
    .mar_in(mar_in[1]), .ram_out(ram_out[1]), .ram_in(ram_in[1]),
    .ir_in(ir_in[1]), .ir_out(ir_out[1]), .a_in(a_in[1]), .a_out(a_out[1]),
    .b_in(b_in[1]), .alu_out(alu_out[1]), .alu_sub(alu_sub[1]),
    .flags_in(flags_in[1]), .out_in(out_in[1]), .halt(halt[1]),
    .t_state(t_state[1]), .instr_done(instr_done[1])
  );

  function automatic logic [14:0] obs(input int k);
    return {out_in[k], flags_in[k], alu_sub[k], alu_out[k], b_in[k], a_out[k], a_in[k],
            ir_out[k], ir_in[k], ram_in[k], ram_out[k], mar_in[k], pc_in[k], pc_out[k], pc_en[k]};
  endfunction

  // Reference model: opcode table from the instruction set, independent of RTL structure.
  function automatic int eff_op(input int op, input bit illegal_halt);
    if (op >= 9 && op <= 13) return illegal_halt ? 15 : 0;
    return op;
  endfunction

  function automatic int last_of(input int op);
    case (op)
      1, 4:    return 3;
      2, 3:    return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [14:0] exp_ctrl(input int op, input int step, input bit c, input bit z);
    if (step == 0) return PC_OUT | MAR_IN;
    if (step == 1) return RAM_OUT | IR_IN | PC_EN;
    case (op)
      1:       return (step == 2) ? (IR_OUT | MAR_IN) : (RAM_OUT | A_IN);
      2, 3: begin
        if (step == 2) return IR_OUT | MAR_IN;
        if (step == 3) return RAM_OUT | B_IN;
        return ALU_OUT | A_IN | FLAGS_IN | ((op == 3) ? ALU_SUB : 15'd0);
      end
      4:       return (step == 2) ? (IR_OUT | MAR_IN) : (A_OUT | RAM_IN);
      5:       return IR_OUT | A_IN;
      6:       return IR_OUT | PC_IN;
      7:       return IR_OUT | (c ? PC_IN : 15'd0);
      8:       return IR_OUT | (z ? PC_IN : 15'd0);
      14:      return A_OUT | OUT_IN;
      default: return 15'd0;
    endcase
  endfunction

  task automatic start(input int k, input int op, input bit c, input bit z);
    rst_n[k]      = 1'b0;
    opcode[k]     = 4'(op);
    carry_flag[k] = c;
    zero_flag[k]  = z;
    repeat (2) @(posedge clk);
    #1 rst_n[k] = 1'b1;
  endtask

  task automatic test_instruction(input int k, input int raw_op, input bit c, input bit z,
                                  input string name);
    int e;
    int last;
    logic [14:0] exp_after;
    e    = eff_op(raw_op, k == 1);
    last = last_of(e);
    start(k, raw_op, c, z);
    @(negedge clk);
    check_count++;
    if (obs(k) !== 15'd0 || t_state[k] !== 3'd0 || instr_done[k] !== 1'b0) begin
      $display("[TB] FAIL %s idle: ctrl=%h t=%0d done=%b, expected ctrl=0 t=0 done=0",
               name, obs(k), t_state[k], instr_done[k]);
    end else pass_count++;
    for (int s = 0; s <= last; s++) begin
      @(negedge clk);
      check_count++;
      if (obs(k) !== exp_ctrl(e, s, c, z) || t_state[k] !== 3'(s) ||
          instr_done[k] !== (s == last) || halt[k] !== 1'b0) begin
        $display("[TB] FAIL %s T%0d: ctrl=%h t=%0d done=%b halt=%b, expected ctrl=%h t=%0d done=%b halt=0",
                 name, s, obs(k), t_state[k], instr_done[k], halt[k],
                 exp_ctrl(e, s, c, z), s, (s == last));
      end else pass_count++;
    end
    @(negedge clk);
    exp_after = (e == 15) ? 15'd0 : (PC_OUT | MAR_IN);
    check_count++;
    if (obs(k) !== exp_after || t_state[k] !== 3'd0 || halt[k] !== (e == 15) ||
        instr_done[k] !== 1'b0) begin
      $display("[TB] FAIL %s after: ctrl=%h t=%0d halt=%b done=%b, expected ctrl=%h t=0 halt=%b done=0",
               name, obs(k), t_state[k], halt[k], instr_done[k], exp_after, (e == 15));
    end else pass_count++;
  endtask

  task automatic test_reset;
    rst_n[0] = 1'b0;
    opcode[0] = 4'h0;
    @(negedge clk);
    check_count++;
    if (obs(0) !== 15'd0 || t_state[0] !== 3'd0 || halt[0] !== 1'b0 || instr_done[0] !== 1'b0) begin
      $display("[TB] FAIL reset_hold: ctrl=%h t=%0d halt=%b done=%b, expected all 0",
               obs(0), t_state[0], halt[0], instr_done[0]);
    end else pass_count++;
    test_instruction(0, 0, 1'b0, 1'b0, "reset_nop");
  endtask

  task automatic test_add_sub;
    test_instruction(0, 2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "add");
    test_instruction(0, 3, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "sub");
  endtask

  task automatic test_branches;
    test_instruction(0, 7, 1'b0, 1'b1, "jc_not_taken");
    test_instruction(0, 7, 1'b1, 1'b0, "jc_taken");
    test_instruction(0, 8, 1'b1, 1'b0, "jz_not_taken");
    test_instruction(0, 8, 1'b0, 1'b1, "jz_taken");
    test_instruction(0, 6, 1'b0, 1'b0, "jmp");
  endtask

  task automatic test_others;
    test_instruction(0, 1, 1'b0, 1'b0, "lda");
    test_instruction(0, 4, 1'b1, 1'b1, "sta");
    test_instruction(0, 5, 1'b0, 1'b1, "ldi");
    test_instruction(0, 14, 1'b1, 1'b0, "out");
  endtask

  task automatic test_halt;
    test_instruction(0, 15, 1'b0, 1'b0, "hlt");
    for (int i = 0; i < 10; i++) begin
      opcode[0] = 4'($urandom_range(15, 0));
      @(negedge clk);
      check_count++;
      if (obs(0) !== 15'd0 || t_state[0] !== 3'd0 || halt[0] !== 1'b1 || instr_done[0] !== 1'b0) begin
        $display("[TB] FAIL halt_frozen %0d: ctrl=%h t=%0d halt=%b done=%b, expected ctrl=0 t=0 halt=1 done=0",
                 i, obs(0), t_state[0], halt[0], instr_done[0]);
      end else pass_count++;
    end
    rst_n[0] = 1'b0;
    #1;
    check_count++;
    if (halt[0] !== 1'b0) begin
      $display("[TB] FAIL halt_clear: halt=%b, expected 0", halt[0]);
    end else pass_count++;
  endtask

  task automatic test_illegal;
    test_instruction(0, 9, 1'b0, 1'b0, "illegal_nop");
    test_instruction(1, 9, 1'b0, 1'b0, "illegal_halt");
    test_instruction(1, 13, 1'b1, 1'b1, "illegal_halt_d");
    test_instruction(1, 2, 1'b0, 1'b0, "add_on_halt_variant");
  endtask

  task automatic test_mid_reset;
    start(0, 2, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check_count++;
    if (obs(0) !== (RAM_OUT | B_IN) || t_state[0] !== 3'd3) begin
      $display("[TB] FAIL mid_reset_t3: ctrl=%h t=%0d, expected ctrl=%h t=3",
               obs(0), t_state[0], RAM_OUT | B_IN);
    end else pass_count++;
    rst_n[0] = 1'b0;
    #1;
    check_count++;
    if (obs(0) !== 15'd0 || t_state[0] !== 3'd0 || instr_done[0] !== 1'b0) begin
      $display("[TB] FAIL mid_reset_abort: ctrl=%h t=%0d done=%b, expected all 0",
               obs(0), t_state[0], instr_done[0]);
    end else pass_count++;
    @(negedge clk);
    check_count++;
    if (obs(0) !== 15'd0 || halt[0] !== 1'b0) begin
      $display("[TB] FAIL mid_reset_hold: ctrl=%h halt=%b, expected 0", obs(0), halt[0]);
    end else pass_count++;
  endtask

  task automatic test_random;
    bit          m_run;
    int          m_step;
    int          e;
    bit          c;
    bit          z;
    logic [14:0] exp;
    bit          exp_done;
    m_run = 1'b0;
    m_step = 0;
    e = 0;
    c = 1'b0;
    z = 1'b0;
    start(0, 0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (m_run && m_step == 0) begin
        int raw;
        raw = $urandom_range(14, 0);
        c = 1'($urandom_range(1, 0));
        z = 1'($urandom_range(1, 0));
        opcode[0] = 4'(raw);
        carry_flag[0] = c;
        zero_flag[0] = z;
        e = eff_op(raw, 1'b0);
      end
      @(negedge clk);
      exp = m_run ? exp_ctrl(e, m_step, c, z) : 15'd0;
      exp_done = m_run && (m_step == last_of(e));
      check_count++;
      if (obs(0) !== exp || t_state[0] !== 3'(m_step) || instr_done[0] !== exp_done ||
          halt[0] !== 1'b0) begin
        $display("[TB] FAIL random cyc %0d op %0d: ctrl=%h t=%0d done=%b halt=%b, expected ctrl=%h t=%0d done=%b halt=0",
                 cyc, e, obs(0), t_state[0], instr_done[0], halt[0], exp, m_step, exp_done);
      end else pass_count++;
      check_count++;
      if (!$onehot0(obs(0) & BUS)) begin
        $display("[TB] FAIL bus_exclusive cyc %0d: drivers=%h, expected at most one", cyc, obs(0) & BUS);
      end else pass_count++;
      if (!m_run) m_run = 1'b1;
      else if (m_step == last_of(e)) m_step = 0;
      else m_step++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    pass_count = 0;
    check_count = 0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      opcode[k] = 4'h0;
      carry_flag[k] = 1'b0;
      zero_flag[k] = 1'b0;
    end
    test_reset;
    test_add_sub;
    test_branches;
    test_others;
    test_halt;
    test_illegal;
    test_mid_reset;
    test_random;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
